md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multiply/divide unit of the execute stage. It consumes MDOp, rs data and rt data
//   from the ID/EX pipeline register, and it owns the architectural HI/LO registers.
//   Multi-cycle MULT/MULTU/DIV/DIVU operations assert busy. The stall unit uses busy and
//   start to hold D-stage mult/div/mfhi/mflo instructions. MFHI/MFLO read HI/LO through
//   the E-stage result mux.
// PARAMETERS
//   MULT_CYCLES  5   busy duration after a MULT/MULTU start, in cycles (>=1)
//   DIV_CYCLES   10  busy duration after a DIV/DIVU start, in cycles (>=1)
// PORTS
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous reset, ACTIVE-LOW: sampled at the clk edge, 0 = reset
//   en       in   1   E-stage instruction valid; 0 = bubble or flushed, the unit ignores MDOp
//   MDOp     in   3   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (optional)
//   A        in   32  rs operand (forwarded)
//   B        in   32  rt operand (forwarded)
//   start    out  1   combinational: en & MDOp in {1,2,3,4,(7)} & !busy
//   busy     out  1   registered: a multi-cycle operation is in flight
//   HI       out  32  architectural HI register
//   LO       out  32  architectural LO register
// BEHAVIOUR
//   - Reset (reset==0 at the edge): HI=0, LO=0, busy=0, cnt=0, tmp_hi=tmp_lo=0.
//     An operation in flight is discarded.
//   - Start edge, i.e. the clk edge with start==1:
//     - tmp_hi/tmp_lo are loaded with the full result, computed from A/B in that cycle.
//     - cnt <= MULT_CYCLES or DIV_CYCLES; busy <= 1.
//   - While cnt>1: cnt decrements each edge.
//   - Edge with cnt==1: HI<=tmp_hi, LO<=tmp_lo, cnt<=0, busy<=0.
//     busy is high for exactly N cycles. HI/LO are visible in the cycle busy falls.
//   - MULT: {HI,LO} = signed(A)*signed(B), 64 bit. MULTU: the same product, unsigned.
//   - DIV: LO = signed quotient truncated toward zero; HI = remainder, with the sign of
//     the dividend. DIVU: the same operation, unsigned.
//   - Divide by zero (B==0): the operation still runs the full busy time. HI/LO keep their
//     old values (tmp_* loaded with the current HI/LO).
//   - 0x80000000 / -1 (DIV): LO=0x80000000, HI=0 (natural 32-bit wrap).
//   - MTHI/MTLO with en & !busy: HI (or LO) <= A at that edge, single cycle, busy stays 0.
//   - MDOp with en while busy: ignored, with no state change. The stall unit prevents this;
//     the unit does not queue.
//   - MDOp 0, or en==0: no effect.
//   - busy is independent of pipeline flushes. A flush of a younger instruction never
//     aborts an in-flight operation; only reset aborts it.
// CONFIGURATION
//   MDU_MADD_EN defined:
//     MDOp 7 = MADD: {HI,LO} <= {HI,LO} + signed(A)*signed(B), busy MULT_CYCLES.
//     The accumulate uses HI/LO as of the start edge.
//   MDU_MADD_EN undefined:
//     MDOp 7 is treated as NOP: start=0, no state change.
// STRUCTURE
//   - md_pkg (shared): MDOp encodings MD_NOP..MD_MADD (3-bit localparams).
//     The same constants are used by the controller and by the ID/EX register's MDOp field.
//   - Sub-module md_calc: purely combinational. Inputs: MDOp, A, B, HI, LO.
//     Outputs: 64-bit {res_hi,res_lo} and div0 flag.
//   - md_unit holds the counter, busy, tmp_hi/tmp_lo, HI and LO, and the MT* write path.
// TESTING
//   1. Reset: drive reset=0 one edge, mid-DIV (cnt=6) -> busy=0, HI=LO=0 next cycle;
//      no later writeback.
//   2. MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//      MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//   3. DIV A=-7, B=2 -> busy 10 cycles -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU A=7, B=2 -> LO=3, HI=1.
//   4. DIV with B=0 after MTHI 0x1234 / MTLO 0x5678 -> busy 10 cycles,
//      HI=0x1234, LO=0x5678 unchanged.
//   5. MULT issued while busy (cycle 3 of a DIV) -> start=0, result equals the DIV result
//      only. en=0 with MDOp=MULT -> start=0, busy stays 0.
//   6. MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 -> after 5 cycles HI=1, LO=0.
//      Without the macro, MDOp 7 -> start=0, HI/LO unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: MDOp encodings, datapath width and op classification.
package md_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MDOP_W = 3;

    localparam logic [MDOP_W-1:0] MD_NOP   = 3'd0;
    localparam logic [MDOP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MDOP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MDOP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MDOP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MDOP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MDOP_W-1:0] MD_MTLO  = 3'd6;
    localparam logic [MDOP_W-1:0] MD_MADD  = 3'd7;

    // Multiply-class ops take the short busy time; divides take the long one.
    function automatic logic is_mult_class(input logic [MDOP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: 64-bit {HI,LO} result for the given MDOp.
// MDU_MADD_EN adds the MADD accumulate result for MDOp 7.
// On divide-by-zero the quotient/remainder are meaningless; div0_o tells the caller.
module md_calc
    import md_pkg::*;
(
    input  logic [MDOP_W-1:0] md_op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [XLEN-1:0]   hi_i,
    input  logic [XLEN-1:0]   lo_i,
    output logic [2*XLEN-1:0] res_o,
    output logic              div0_o
);

    logic signed [2*XLEN-1:0] a_sx;
    logic signed [2*XLEN-1:0] b_sx;
    logic signed [2*XLEN-1:0] smul;
    logic        [2*XLEN-1:0] umul;
    logic                     s_ovf;
    logic signed [XLEN-1:0]   sa;
    logic signed [XLEN-1:0]   sdvs;
    logic signed [XLEN-1:0]   sq;
    logic signed [XLEN-1:0]   sr;
    logic        [XLEN-1:0]   udvs;
    logic        [XLEN-1:0]   uq;
    logic        [XLEN-1:0]   ur;

    assign a_sx = {{XLEN{a_i[XLEN-1]}}, a_i};
    assign b_sx = {{XLEN{b_i[XLEN-1]}}, b_i};
    assign smul = a_sx * b_sx;
    assign umul = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

    // Divisor of 1 stands in for B==0 (result discarded) and for MIN/-1, where
    // dividing by 1 gives exactly the wrapped quotient 0x80000000, remainder 0.
    assign div0_o = (b_i == '0);
    assign s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign sa     = a_i;
    assign sdvs   = (div0_o || s_ovf) ? 32'sd1 : b_i;
    assign sq     = sa / sdvs;
    assign sr     = sa % sdvs;
    assign udvs   = div0_o ? 32'd1 : b_i;
    assign uq     = a_i / udvs;
    assign ur     = a_i % udvs;

    // Result select; non-arithmetic ops pass the current HI/LO through.
    always_comb begin
        res_o = {hi_i, lo_i};
        case (md_op_i)
            MD_MULT:  res_o = smul;
            MD_MULTU: res_o = umul;
            MD_DIV:   res_o = {sr, sq};
            MD_DIVU:  res_o = {ur, uq};
`ifdef MDU_MADD_EN
            MD_MADD:  res_o = {hi_i, lo_i} + smul;
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Result is computed at the start edge,
// held in tmp_hi/tmp_lo, and committed after MULT_CYCLES/DIV_CYCLES of busy.
// Optional feature macro: MDU_MADD_EN (MDOp 7 = MADD accumulate; otherwise a NOP).
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MDOP_W-1:0] MDOp,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    output logic              start,
    output logic              busy,
    output logic [XLEN-1:0]   HI,
    output logic [XLEN-1:0]   LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;
    logic [XLEN-1:0]   tmp_hi_q, tmp_hi_d;
    logic [XLEN-1:0]   tmp_lo_q, tmp_lo_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              busy_q,   busy_d;
    logic              start_op;
    logic [2*XLEN-1:0] calc_res;
    logic              calc_div0;

    md_calc u_calc (
        .md_op_i (MDOp),
        .a_i     (A),
        .b_i     (B),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .res_o   (calc_res),
        .div0_o  (calc_div0)
    );

    // Ops that launch a multi-cycle operation.
    always_comb begin
        start_op = 1'b0;
        case (MDOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: start_op = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD: start_op = 1'b1;
`endif
            default: start_op = 1'b0;
        endcase
    end

    assign start = en & start_op & ~busy_q;

    // Next state: launch, count down and commit, or single-cycle MTHI/MTLO write.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            if (calc_div0 && !is_mult_class(MDOp)) begin
                tmp_hi_d = hi_q;
                tmp_lo_d = lo_q;
            end else begin
                tmp_hi_d = calc_res[2*XLEN-1:XLEN];
                tmp_lo_d = calc_res[XLEN-1:0];
            end
            cnt_d  = is_mult_class(MDOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d   = tmp_hi_q;
                lo_d   = tmp_lo_q;
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (en && (MDOp == MD_MTHI)) begin
            hi_d = A;
        end else if (en && (MDOp == MD_MTLO)) begin
            lo_d = A;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of single operations plus hand sequences
// for reset mid-divide, issue-while-busy, en gating and MDOp 7 (MDU_MADD_EN aware).
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_start;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Issue one op for one cycle, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic st, output int cyc);
        en   = 1'b1;
        MDOp = op;
        A    = a;
        B    = b;
        #1;
        st = start;
        step();
        en   = 1'b0;
        MDOp = MD_NOP;
        cyc  = 0;
        while (busy && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic st;
        int   cyc;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'h0000_0003, 10};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{MD_MTHI,  32'h0000_1234, 32'h0000_0000, 1'b0, 32'h0000_1234, 32'h8000_0000, 0};
        vecs[6]  = '{MD_MTLO,  32'h0000_5678, 32'h0000_0000, 1'b0, 32'h0000_1234, 32'h0000_5678, 0};
        vecs[7]  = '{MD_DIV,   32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_1234, 32'h0000_5678, 10};
        vecs[8]  = '{MD_DIVU,  32'h0000_0009, 32'h0000_0000, 1'b1, 32'h0000_1234, 32'h0000_5678, 10};
        vecs[9]  = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[10] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF, 10};
        vecs[11] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[12] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[13] = '{MD_NOP,   32'h0000_0055, 32'h0000_0066, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 0};
        vecs[14] = '{MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 10};

        reset = 1'b0;
        en    = 1'b0;
        MDOp  = MD_NOP;
        A     = '0;
        B     = '0;
        step();
        step();
        chk("reset_busy", 0, 32'(busy), 32'd0);
        chk("reset_hi",   0, HI, 32'd0);
        chk("reset_lo",   0, LO, 32'd0);
        reset = 1'b1;
        step();

        // Reset mid-DIV (cnt=6): operation discarded, no later writeback.
        en = 1'b1; MDOp = MD_DIV; A = 32'd7; B = 32'd2;
        step();
        en = 1'b0; MDOp = MD_NOP;
        repeat (4) step();
        chk("middiv_busy", 0, 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_abort_busy", 0, 32'(busy), 32'd0);
        chk("rst_abort_hi",   0, HI, 32'd0);
        chk("rst_abort_lo",   0, LO, 32'd0);
        repeat (15) step();
        chk("no_wb_busy", 0, 32'(busy), 32'd0);
        chk("no_wb_hi",   0, HI, 32'd0);
        chk("no_wb_lo",   0, LO, 32'd0);

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, st, cyc);
            chk("vec_start", i, 32'(st), 32'(vecs[i].exp_start));
            chk("vec_cycles", i, 32'(cyc), 32'(vecs[i].exp_cyc));
            chk("vec_hi", i, HI, vecs[i].exp_hi);
            chk("vec_lo", i, LO, vecs[i].exp_lo);
        end

        // MULT issued in cycle 3 of a DIV is ignored; DIV result only.
        en = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
        step();
        en = 1'b0; MDOp = MD_NOP;
        step();
        step();
        en = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd3;
        #1;
        chk("busy_issue_start", 0, 32'(start), 32'd0);
        chk("busy_issue_busy",  0, 32'(busy), 32'd1);
        step();
        en = 1'b0; MDOp = MD_NOP;
        cyc = 3;
        while (busy && cyc < 100) begin
            step();
            cyc++;
        end
        chk("busy_issue_cycles", 0, 32'(cyc), 32'd10);
        chk("busy_issue_hi", 0, HI, 32'd2);
        chk("busy_issue_lo", 0, LO, 32'd14);
        step();
        chk("busy_issue_noqueue", 0, 32'(busy), 32'd0);

        // en=0 gates a MULT.
        en = 1'b0; MDOp = MD_MULT; A = 32'd5; B = 32'd5;
        #1;
        chk("en0_start", 0, 32'(start), 32'd0);
        step();
        MDOp = MD_NOP;
        chk("en0_busy", 0, 32'(busy), 32'd0);
        chk("en0_lo",   0, LO, 32'd14);

`ifdef MDU_MADD_EN
        run_op(MD_MTHI, 32'h0000_0000, 32'd0, st, cyc);
        run_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, st, cyc);
        run_op(MD_MADD, 32'd1, 32'd1, st, cyc);
        chk("madd_start",  0, 32'(st), 32'd1);
        chk("madd_cycles", 0, 32'(cyc), 32'd5);
        chk("madd_hi",     0, HI, 32'h0000_0001);
        chk("madd_lo",     0, LO, 32'h0000_0000);
`else
        run_op(MD_MTHI, 32'h0000_AAAA, 32'd0, st, cyc);
        run_op(MD_MTLO, 32'h0000_BBBB, 32'd0, st, cyc);
        run_op(MD_MADD, 32'd1, 32'd1, st, cyc);
        chk("op7_start",  0, 32'(st), 32'd0);
        chk("op7_cycles", 0, 32'(cyc), 32'd0);
        chk("op7_hi",     0, HI, 32'h0000_AAAA);
        chk("op7_lo",     0, LO, 32'h0000_BBBB);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
